// File: rtl/fmulsu_div.sv
// rtl/fmulsu_div.sv - sequential restoring fractional divider, inverse of FMULSU
module fmulsu_div #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_r1,
    input  logic [W-1:0] i_r0,
    input  logic [W-1:0] i_rr,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_q,
    output logic         o_ovf,
    output logic         o_dz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Counter covers one setup step (0) plus 2*W quotient-bit steps (1..2W).
    localparam int CW = $clog2(2 * W + 1);
    localparam logic [CW-1:0]  LAST_STEP = CW'(2 * W);
    localparam logic [2*W-1:0] POS_MAX   = (2*W)'((1 << (W - 1)) - 1);
    localparam logic [2*W-1:0] NEG_MAX   = (2*W)'(1 << (W - 1));

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] dvd_q, dvd_d;    // raw dividend, then |D|, then shifts into quotient
    logic [W:0]     dvs_q, dvs_d;    // 2*V, the effective divisor
    logic [W:0]     rem_q, rem_d;    // partial remainder, always < 2*V
    logic           neg_q, neg_d;
    logic [W-1:0]   q_q, q_d;
    logic           ovf_q, ovf_d;
    logic           dz_q, dz_d;

    logic [W+1:0]   trial;
    logic           fits;

    // Shift the next dividend bit into the remainder and test against the divisor.
    always_comb begin
        trial = {rem_q, dvd_q[2*W-1]};
        fits  = (trial >= {1'b0, dvs_q});
    end

    // Next-state and datapath control; back-to-back starts are accepted in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        q_d     = q_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (i_start) begin
                    dvd_d   = {i_r1, i_r0};
                    dvs_d   = {i_rr, 1'b0};
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '0) begin
                    // Setup step: take the magnitude; 0x8000 maps onto itself.
                    neg_d = dvd_q[2*W-1];
                    dvd_d = dvd_q[2*W-1] ? ('0 - dvd_q) : dvd_q;
                    rem_d = '0;
                end else begin
                    rem_d = fits ? (trial[W:0] - dvs_q) : trial[W:0];
                    dvd_d = {dvd_q[2*W-2:0], fits};
                    if (cnt_q == LAST_STEP) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                ovf_d   = 1'b0;
                dz_d    = 1'b0;
                if (dvs_q == '0) begin
                    dz_d = 1'b1;
                    q_d  = neg_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                end else if (neg_q) begin
                    if (dvd_q > NEG_MAX) begin
                        ovf_d = 1'b1;
                        q_d   = {1'b1, {(W-1){1'b0}}};
                    end else begin
                        q_d = '0 - dvd_q[W-1:0];
                    end
                end else begin
                    if (dvd_q > POS_MAX) begin
                        ovf_d = 1'b1;
                        q_d   = {1'b0, {(W-1){1'b1}}};
                    end else begin
                        q_d = dvd_q[W-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any running operation.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            neg_q   <= 1'b0;
            q_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign o_busy = (state_q == S_CALC) || (state_q == S_FIX);
    assign o_done = (state_q == S_DONE);
    assign o_q    = q_q;
    assign o_ovf  = ovf_q;
    assign o_dz   = dz_q;

endmodule

// File: tb/tb_fmulsu_div.sv
// tb/tb_fmulsu_div.sv - randomized self-checking bench for fmulsu_div
module tb_fmulsu_div;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_r1 = '0;
    logic [7:0] i_r0 = '0;
    logic [7:0] i_rr = '0;
    logic       o_busy, o_done, o_ovf, o_dz;
    logic [7:0] o_q;

    int checks = 0;
    int failures = 0;

    fmulsu_div #(.W(8)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_start(i_start),
        .i_r1   (i_r1),
        .i_r0   (i_r0),
        .i_rr   (i_rr),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_q    (o_q),
        .o_ovf  (o_ovf),
        .o_dz   (o_dz)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // q = D / (2V) truncated toward zero, then saturated to signed 8 bits.
    task automatic model(input logic [15:0] d, input logic [7:0] v,
                         output int q, output int ovf, output int dz);
        int sd;
        int qq;
        sd = int'($signed(d));
        ovf = 0;
        dz = 0;
        if (v == 8'd0) begin
            dz = 1;
            q = (sd >= 0) ? 'h7F : 'h80;
        end else begin
            qq = sd / (2 * int'(v));
            if (qq > 127) begin
                q = 'h7F; ovf = 1;
            end else if (qq < -128) begin
                q = 'h80; ovf = 1;
            end else begin
                q = qq & 'hFF;
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start(input logic [15:0] d, input logic [7:0] v);
        {i_r1, i_r0} = d;
        i_rr = v;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Waits for o_done after an accepting edge; returns cycles elapsed (-1 on timeout).
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (o_done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] d, input logic [7:0] v);
        int lat, q, ovf, dz;
        model(d, v, q, ovf, dz);
        start(d, v);
        wait_done(lat);
        check({tag, "_lat"}, lat, 18);
        check({tag, "_q"}, int'(o_q), q);
        check({tag, "_ovf"}, int'(o_ovf), ovf);
        check({tag, "_dz"}, int'(o_dz), dz);
        check({tag, "_busy"}, int'(o_busy), 0);
    endtask

    task automatic no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (o_done) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        int lat;
        logic [15:0] rd;
        logic [7:0]  rv;

        tick();
        tick();
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_q", int'(o_q), 0);
        check("rst_ovf", int'(o_ovf), 0);
        check("rst_dz", int'(o_dz), 0);
        i_rst = 1'b0;
        tick();

        // Directed vectors; consecutive calls also exercise starts in DONE.
        run_op("rt_half", 16'h6000, 8'hC0);
        run_op("neg_one", 16'h8000, 8'h80);
        run_op("neg_half", 16'hC000, 8'h80);
        run_op("trunc", 16'hFFFF, 8'h01);
        run_op("ovf_pos", 16'h4000, 8'h01);
        run_op("ovf_neg", 16'h8000, 8'h01);
        run_op("dz_pos", 16'h1234, 8'h00);
        run_op("dz_neg", 16'hF000, 8'h00);
        run_op("edge_m128", 16'hFF00, 8'h01);
        run_op("edge_p127", 16'h00FE, 8'h01);
        run_op("edge_p128", 16'h0100, 8'h01);
        run_op("zero", 16'h0000, 8'hFF);
        tick();

        // Inputs changed and start pulsed mid-operation must be ignored.
        start(16'h6000, 8'hC0);
        repeat (4) tick();
        {i_r1, i_r0} = 16'h8000;
        i_rr = 8'h01;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        lat = -1;
        for (int c = 6; c <= 40; c++) begin
            tick();
            if (o_done) begin
                lat = c;
                break;
            end
        end
        check("ign_lat", lat, 18);
        check("ign_q", int'(o_q), 'h40);
        check("ign_ovf", int'(o_ovf), 0);
        // Start in the DONE cycle is accepted.
        run_op("b2b", 16'hC000, 8'h80);
        no_done("ign_extra_done", 25);

        // Reset mid-operation aborts and clears everything.
        start(16'h6000, 8'hC0);
        repeat (8) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("abort_busy", int'(o_busy), 0);
        check("abort_done", int'(o_done), 0);
        check("abort_q", int'(o_q), 0);
        check("abort_ovf", int'(o_ovf), 0);
        check("abort_dz", int'(o_dz), 0);
        no_done("abort_no_done", 25);
        run_op("after_rst", 16'h6000, 8'hC0);

        // Randomized operands, with occasional idle gaps and zero divisors.
        for (int n = 0; n < 200; n++) begin
            rd = 16'($urandom);
            rv = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 3) == 0) tick();
            run_op("rand", rd, rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
